// File: rtl/axi_read_arbiter_if.sv
// axi_read_arbiter_if: AXI read-channel (AR + R) bundle, ID width parameterised per side.
interface axi_read_arbiter_if #(parameter int ID_BITS = 4);
  logic [ID_BITS-1:0] arid;
  logic [31:0]        araddr;
  logic [3:0]         arlen;
  logic [2:0]         arsize;
  logic [1:0]         arburst;
  logic               arvalid;
  logic               arready;
  logic [ID_BITS-1:0] rid;
  logic [31:0]        rdata;
  logic [1:0]         rresp;
  logic               rlast;
  logic               rvalid;
  logic               rready;
  modport master (output arid, araddr, arlen, arsize, arburst, arvalid, rready,
                  input  arready, rid, rdata, rresp, rlast, rvalid);
  modport slave  (input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
                  output arready, rid, rdata, rresp, rlast, rvalid);
endinterface

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: two-master round-robin AXI read arbiter, one outstanding transaction.
module axi_read_arbiter #(
  parameter int ID_BITS  = 4,
  parameter int IDS_BITS = 8
) (
  input logic clk,
  input logic rst,
  axi_read_arbiter_if.slave  m0,
  axi_read_arbiter_if.slave  m1,
  axi_read_arbiter_if.master s
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state;
  logic   grant, ptr;
  logic   in_addr, in_data, a0, a1, d0, d1;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= 1'b0;
      ptr   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (m0.arvalid || m1.arvalid) begin
          grant <= (m0.arvalid && m1.arvalid) ? ptr : m1.arvalid;
          state <= ADDR;
        end
        ADDR: if (s.arvalid && s.arready) state <= DATA;
        DATA: if (s.rvalid && s.rready && s.rlast) begin
          ptr   <= ~grant;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // Gating with rst keeps every output quiet while reset is held, whatever state is left over.
  assign in_addr = (state == ADDR) && !rst;
  assign in_data = (state == DATA) && !rst;
  assign a0 = in_addr && !grant;
  assign a1 = in_addr && grant;
  assign d0 = in_data && !grant;
  assign d1 = in_data && grant;
  assign s.arvalid  = (a0 && m0.arvalid) || (a1 && m1.arvalid);
  assign s.arid     = a0 ? IDS_BITS'({4'(1'b0), m0.arid}) : a1 ? IDS_BITS'({4'(1'b1), m1.arid}) : '0;
  assign s.araddr   = a0 ? m0.araddr  : a1 ? m1.araddr  : '0;
  assign s.arlen    = a0 ? m0.arlen   : a1 ? m1.arlen   : '0;
  assign s.arsize   = a0 ? m0.arsize  : a1 ? m1.arsize  : '0;
  assign s.arburst  = a0 ? m0.arburst : a1 ? m1.arburst : '0;
  assign m0.arready = a0 && s.arready;
  assign m1.arready = a1 && s.arready;
  assign s.rready   = (d0 && m0.rready) || (d1 && m1.rready);
  assign m0.rvalid  = d0 && s.rvalid;
  assign m0.rid     = d0 ? s.rid[ID_BITS-1:0] : '0;
  assign m0.rdata   = d0 ? s.rdata : '0;
  assign m0.rresp   = d0 ? s.rresp : '0;
  assign m0.rlast   = d0 && s.rlast;
  assign m1.rvalid  = d1 && s.rvalid;
  assign m1.rid     = d1 ? s.rid[ID_BITS-1:0] : '0;
  assign m1.rdata   = d1 ? s.rdata : '0;
  assign m1.rresp   = d1 ? s.rresp : '0;
  assign m1.rlast   = d1 && s.rlast;
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: vector-table bench; each record is one clock of stimulus plus expected routing.
module tb_axi_read_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  axi_read_arbiter_if #(.ID_BITS(4)) m0_if ();
  axi_read_arbiter_if #(.ID_BITS(4)) m1_if ();
  axi_read_arbiter_if #(.ID_BITS(8)) s_if ();
  axi_read_arbiter #(.ID_BITS(4), .IDS_BITS(8)) dut (
    .clk(clk), .rst(rst), .m0(m0_if.slave), .m1(m1_if.slave), .s(s_if.master)
  );
  // in = {rst, arvalid0, arvalid1, arready_s, rvalid_s, rlast_s, rready0, rready1}
  // ag/rg = which master the AR/R path is expected to be routed to (0 none, 1 M0, 2 M1)
  typedef struct {
    bit [7:0] in;
    bit [1:0] ag;
    bit [1:0] rg;
  } vec_t;
  vec_t tbl[$];
  int n_vec = 0;
  int n_err = 0;
  task automatic add(input bit [7:0] in, input bit [1:0] ag, input bit [1:0] rg);
    vec_t v;
    v.in = in;
    v.ag = ag;
    v.rg = rg;
    tbl.push_back(v);
  endtask
  initial begin
    #100000;
    n_err++;
    $display("FAIL: timeout waiting for vector sequence to complete");
    $finish;
  end
  initial begin
    bit r, v0, v1, ars, rvs, rls, rr0, rr1;
    logic [132:0] act, expv;
    logic [48:0]  pay;
    logic [39:0]  r0, r1;
    logic         e_av, e_rrs;
    m0_if.arid = 4'h3; m0_if.araddr = 32'h0000_1000; m0_if.arlen = 4'd0;
    m0_if.arsize = 3'd2; m0_if.arburst = 2'd1;
    m1_if.arid = 4'h5; m1_if.araddr = 32'h0000_2000; m1_if.arlen = 4'd3;
    m1_if.arsize = 3'd1; m1_if.arburst = 2'd2;
    s_if.rresp = 2'b10;
    add(8'b1000_0000, 2'd0, 2'd0); // 0 reset
    add(8'b1100_0000, 2'd0, 2'd0); // 1 reset beats a request
    add(8'b0100_0000, 2'd0, 2'd0); // 2 M0 alone, IDLE drives nothing
    add(8'b0101_0000, 2'd1, 2'd0); // 3 AR to slave, id 03
    add(8'b0000_1110, 2'd0, 2'd1); // 4 DEADBEEF last beat to M0
    add(8'b0000_1010, 2'd0, 2'd0); // 5 back in IDLE, beat ignored
    add(8'b1000_0000, 2'd0, 2'd0); // 6 reset
    add(8'b0110_0000, 2'd0, 2'd0); // 7 both request
    add(8'b0111_0000, 2'd1, 2'd0); // 8 M0 first
    add(8'b0010_1111, 2'd0, 2'd1); // 9 M0 last beat
    add(8'b0010_0000, 2'd0, 2'd0); // 10 idle gap
    add(8'b0011_0000, 2'd2, 2'd0); // 11 M1, id 15
    add(8'b0000_1101, 2'd0, 2'd2); // 12 M1 last beat
    add(8'b0110_0000, 2'd0, 2'd0); // 13 both, pointer back at M0
    for (int i = 0; i < 5; i++) add(8'b0110_1011, 2'd1, 2'd0); // 14..18 ARREADY_S low
    add(8'b0111_0000, 2'd1, 2'd0); // 19 handshake
    add(8'b0010_1110, 2'd0, 2'd1); // 20 M0 last beat
    add(8'b0110_0000, 2'd0, 2'd0); // 21 both again
    add(8'b0111_0000, 2'd2, 2'd0); // 22 M1 wins, burst of 4
    add(8'b0110_1001, 2'd0, 2'd2); // 23 beat 0
    add(8'b0110_1001, 2'd0, 2'd2); // 24 beat 1
    add(8'b0110_1000, 2'd0, 2'd2); // 25 beat 2 stalled by RREADY_M1
    add(8'b0110_1001, 2'd0, 2'd2); // 26 beat 2
    add(8'b0110_1101, 2'd0, 2'd2); // 27 beat 3 last
    add(8'b0110_0000, 2'd0, 2'd0); // 28 both, M0 turn
    add(8'b0111_0000, 2'd1, 2'd0); // 29 M0 AR
    add(8'b0010_1011, 2'd0, 2'd1); // 30 mid-burst beat
    add(8'b1010_1111, 2'd0, 2'd0); // 31 reset mid-burst
    add(8'b0010_1111, 2'd0, 2'd0); // 32 IDLE, no stale beat
    add(8'b0010_0000, 2'd2, 2'd0); // 33 M1 granted
    add(8'b0001_0000, 2'd2, 2'd0); // 34 M1 drops ARVALID, no handshake
    add(8'b0011_0000, 2'd2, 2'd0); // 35 reasserted, handshake
    add(8'b0000_1101, 2'd0, 2'd2); // 36 M1 last beat
    add(8'b0000_0000, 2'd0, 2'd0); // 37 idle
    rst = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      {r, v0, v1, ars, rvs, rls, rr0, rr1} = tbl[i].in;
      rst = r;
      m0_if.arvalid = v0;
      m1_if.arvalid = v1;
      s_if.arready = ars;
      s_if.rvalid = rvs;
      s_if.rlast = rls;
      m0_if.rready = rr0;
      m1_if.rready = rr1;
      s_if.rdata = (i == 4) ? 32'hDEAD_BEEF : 32'hC0DE_0000 + 32'(i);
      s_if.rid = (i == 4) ? 8'h03 : {4'hA, 4'(i)};
      #1;
      e_av  = (tbl[i].ag == 2'd1) ? v0 : (tbl[i].ag == 2'd2) ? v1 : 1'b0;
      e_rrs = (tbl[i].rg == 2'd1) ? rr0 : (tbl[i].rg == 2'd2) ? rr1 : 1'b0;
      pay = (tbl[i].ag == 2'd1) ? {8'h03, 32'h0000_1000, 4'd0, 3'd2, 2'd1} :
            (tbl[i].ag == 2'd2) ? {8'h15, 32'h0000_2000, 4'd3, 3'd1, 2'd2} : 49'd0;
      r0 = (tbl[i].rg == 2'd1) ? {rvs, s_if.rid[3:0], s_if.rdata, 2'b10, rls} : 40'd0;
      r1 = (tbl[i].rg == 2'd2) ? {rvs, s_if.rid[3:0], s_if.rdata, 2'b10, rls} : 40'd0;
      expv = {e_av, pay, tbl[i].ag == 2'd1 && ars, tbl[i].ag == 2'd2 && ars, r0, r1, e_rrs};
      act = {s_if.arvalid, s_if.arid, s_if.araddr, s_if.arlen, s_if.arsize, s_if.arburst,
             m0_if.arready, m1_if.arready,
             m0_if.rvalid, m0_if.rid, m0_if.rdata, m0_if.rresp, m0_if.rlast,
             m1_if.rvalid, m1_if.rid, m1_if.rdata, m1_if.rresp, m1_if.rlast, s_if.rready};
      n_vec++;
      if (act !== expv) begin
        n_err++;
        $display("FAIL vec%0d: got %h want %h", i, act, expv);
      end
      if (r && act !== '0) begin
        n_err++;
        $display("FAIL vec%0d: outputs not all 0 during reset: %h", i, act);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    if (n_err == 0) $display("PASS");
    else $display("FAIL");
    $finish;
  end
endmodule
